usb_tx_scheduler: RTL and testbench
===================================

Name: usb_tx_scheduler

Overview:
- Transmit-side sequencer between the receive-path FIFOs (PID, non-data, data, data-CRC) and the transmit shifter/line driver.
- Pulls one queued PID and frames a complete USB packet: SYNC, PID, payload by PID class, CRC bytes, then EOP.
- Meters one byte per byte-period and drives the shifter load strobe and the EOP request.
- Replaces ad-hoc FIFO reads with a single timed, ordered scheduler.

Parameters:
- BYTE_CLKS, 64, clocks per transmitted byte (8 bits x 8 clk/bit); legal range 4 to 256.
- EOP_CLKS, 24, clocks eop_enable is held (SE0 2 bits + J 1 bit).
- MAX_PAYLOAD, 64, maximum data bytes per DATA packet.

Ports:
- clk  in  1  system clock
- n_rst  in  1  synchronous active-low reset
- tx_enable  in  1  permits starting a new packet; sampled only in IDLE
- pid_empty  in  1  PID FIFO empty
- pid_rdata  in  8  PID FIFO head (first-word fall-through)
- pid_ren  out  1  PID FIFO pop
- nd_empty  in  1  non-data FIFO empty
- nd_rdata  in  8  non-data FIFO head
- nd_ren  out  1  non-data FIFO pop
- data_empty  in  1  data FIFO empty
- data_rdata  in  8  data FIFO head
- data_ren  out  1  data FIFO pop
- dcrc_empty  in  1  data-CRC FIFO empty
- dcrc_rdata  in  8  data-CRC FIFO head
- dcrc_ren  out  1  data-CRC FIFO pop
- load_enable  out  1  one-cycle shifter load strobe
- tx_byte  out  8  byte presented with load_enable; 0x00 otherwise
- eop_enable  out  1  EOP request to line driver
- busy  out  1  high in every state except IDLE
- tx_error  out  1  one-cycle error pulse

Behaviour:
- Reset: synchronous, active-low, on the rising edge of clk.
  - All outputs return to 0, the state returns to IDLE, and the counters clear.
  - A reset mid-packet abandons the packet with no EOP and no further pops.
- FIFOs are first-word fall-through. A *_ren pulse pops the head in the same cycle its value is loaded.
- Byte slot: BYTE_CLKS cycles, counted by slot_cnt from 0 to BYTE_CLKS-1.
  - In cycle 0 of each slot: load_enable=1, tx_byte is valid, and the source ren=1.
  - In the last cycle the state advances.
- PID check: pid_rdata[7:4] must equal ~pid_rdata[3:0].
- PID classes:
  - TOKEN (OUT 0xE1, IN 0x69, SOF 0xA5, SETUP 0x2D): 2 nd bytes.
  - DATA (DATA0 0xC3, DATA1 0x4B): data bytes, then 2 dcrc bytes.
  - HANDSHAKE (ACK 0xD2, NAK 0x5A, STALL 0x1E): no payload.
  - Any other PID that passes the check is sent as HANDSHAKE.
- States and transitions:
  - IDLE, when tx_enable=1 and pid_empty=0:
    - PID check fails: pid_ren=1 and tx_error=1 for that one cycle; remain in IDLE.
    - PID check passes: go to SYNC next cycle.
  - SYNC: one slot, tx_byte=0x80, no pop. Then go to PID.
  - PID: one slot, tx_byte=pid_rdata, pid_ren=1. The class is registered in cycle 0. Then go to TOKEN, DATA or EOP by class.
  - TOKEN: two slots from nd.
    - If nd_empty=1 at a slot's cycle 0: no load, tx_error=1, go to EOP.
  - DATA: one slot per data byte.
    - At cycle 0, if data_empty=1 or byte_cnt=MAX_PAYLOAD, no load occurs; go directly to CRC next cycle.
    - Zero-length payloads are legal.
  - CRC: two slots from dcrc.
    - If dcrc_empty=1 at a slot's cycle 0: no load, tx_error=1, go to EOP.
  - EOP: eop_enable=1 for exactly EOP_CLKS cycles, then IDLE.
- busy=1 from the first SYNC cycle through the last EOP cycle.
- tx_enable deasserting mid-packet has no effect; the packet completes.
- Latency: if IDLE sees a valid start at edge k:
  - SYNC load in cycle k+1.
  - PID load in cycle k+1+BYTE_CLKS.
  - eop_enable rises 1 cycle after the last slot ends.
- Counters:
  - slot_cnt is 8 bits and wraps only by reload.
  - byte_cnt is 7 bits, saturates at MAX_PAYLOAD, and clears in IDLE.
- Only one *_ren is high in any cycle, and never outside a slot's cycle 0 (except the IDLE invalid-PID drop).

Test Plan:
- BYTE_CLKS=8, PID FIFO {0xD2}, tx_enable=1 -> loads 0x80 then 0xD2, 8 cycles apart; eop_enable high 24 cycles; busy falls with eop_enable; pid_empty=1 afterwards.
- PID 0x69, nd {0x81,0x0A} -> loads 0x80,0x69,0x81,0x0A at cycles k+1,+9,+17,+25; nd_ren exactly 2 pulses; then EOP.
- PID 0xC3, data {0x11,0x22,0x33}, dcrc {0xAB,0xCD} -> loads 0x80,0xC3,0x11,0x22,0x33,0xAB,0xCD; data_ren 3 pulses; dcrc_ren 2 pulses; no tx_error.
- PID 0x4B with 70 bytes in data FIFO, MAX_PAYLOAD=64 -> exactly 64 data loads then 2 CRC loads; 6 bytes remain in data FIFO.
- Error cases:
  - PID 0x12 -> single pid_ren plus tx_error pulse in IDLE; no load_enable; busy stays 0.
  - Token with nd holding 1 byte -> one payload load, then tx_error and EOP.
- n_rst low during DATA slot 2 -> next edge: all outputs 0, state IDLE; no pops until tx_enable restarts with a fresh SYNC.

Source files
------------

// File: rtl/usb_tx_scheduler_if.sv
// Bundle between the transmit scheduler, its four first-word-fall-through source FIFOs
// and the shifter/line driver.
interface usb_tx_scheduler_if;
  // Strobe semantics: a FIFO's *_rdata is valid whenever its *_empty is low. A one-cycle
  // *_ren pops that head. The pop lands in the same cycle in which load_enable presents
  // the byte on tx_byte, so the next head is visible from the following cycle onward.
  logic       tx_enable;
  logic       pid_empty;
  logic [7:0] pid_rdata;
  logic       pid_ren;
  logic       nd_empty;
  logic [7:0] nd_rdata;
  logic       nd_ren;
  logic       data_empty;
  logic [7:0] data_rdata;
  logic       data_ren;
  logic       dcrc_empty;
  logic [7:0] dcrc_rdata;
  logic       dcrc_ren;
  logic       load_enable;
  logic [7:0] tx_byte;
  logic       eop_enable;
  logic       busy;
  logic       tx_error;

  modport master (
    input  tx_enable, pid_empty, pid_rdata, nd_empty, nd_rdata,
           data_empty, data_rdata, dcrc_empty, dcrc_rdata,
    output pid_ren, nd_ren, data_ren, dcrc_ren,
           load_enable, tx_byte, eop_enable, busy, tx_error
  );

  modport slave (
    output tx_enable, pid_empty, pid_rdata, nd_empty, nd_rdata,
           data_empty, data_rdata, dcrc_empty, dcrc_rdata,
    input  pid_ren, nd_ren, data_ren, dcrc_ren,
           load_enable, tx_byte, eop_enable, busy, tx_error
  );
endinterface

// File: rtl/usb_tx_scheduler.sv
// USB transmit scheduler. It frames SYNC, PID, payload, CRC and EOP and meters one byte
// per BYTE_CLKS slot. The decision for each slot is registered on the edge that opens the slot.
module usb_tx_scheduler #(
  parameter int BYTE_CLKS   = 64,
  parameter int EOP_CLKS    = 24,
  parameter int MAX_PAYLOAD = 64
) (
  input  logic                 clk,
  input  logic                 n_rst,
  usb_tx_scheduler_if.master   bus,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC  = 3'd1,
    S_PID   = 3'd2,
    S_TOKEN = 3'd3,
    S_DATA  = 3'd4,
    S_CRC   = 3'd5,
    S_EOP   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    C_TOKEN = 2'd0,
    C_DATA  = 2'd1,
    C_HS    = 2'd2
  } cls_e;

  localparam logic [7:0] SLOT_LAST = 8'(BYTE_CLKS - 1);
  localparam logic [7:0] EOP_LAST  = 8'(EOP_CLKS - 1);
  localparam logic [6:0] MAX_BYTES = 7'(MAX_PAYLOAD);
  localparam logic [7:0] SYNC_BYTE = 8'h80;

  state_e     state_q;
  cls_e       cls_q;
  logic [7:0] slot_cnt_q;
  logic [6:0] byte_cnt_q;
  logic       second_q;
  logic       skip_q;
  logic       load_enable_q;
  logic [7:0] tx_byte_q;
  logic       eop_enable_q;
  logic       busy_q;
  logic       tx_error_q;
  logic       pid_ren_q;
  logic       nd_ren_q;
  logic       data_ren_q;
  logic       dcrc_ren_q;

  logic pid_ok;
  logic slot_end;

  assign pid_ok   = (bus.pid_rdata[7:4] == ~bus.pid_rdata[3:0]);
  assign slot_end = (slot_cnt_q == SLOT_LAST);

  function automatic cls_e classify(input logic [7:0] pid);
    case (pid)
      8'hE1, 8'h69, 8'hA5, 8'h2D: return C_TOKEN;
      8'hC3, 8'h4B:               return C_DATA;
      default:                    return C_HS;
    endcase
  endfunction

  // skip_q marks a slot that opened with nothing to load.
  // Such a slot lasts a single cycle before the state moves on.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q       <= S_IDLE;
      cls_q         <= C_HS;
      slot_cnt_q    <= 8'd0;
      byte_cnt_q    <= 7'd0;
      second_q      <= 1'b0;
      skip_q        <= 1'b0;
      load_enable_q <= 1'b0;
      tx_byte_q     <= 8'h00;
      eop_enable_q  <= 1'b0;
      busy_q        <= 1'b0;
      tx_error_q    <= 1'b0;
      pid_ren_q     <= 1'b0;
      nd_ren_q      <= 1'b0;
      data_ren_q    <= 1'b0;
      dcrc_ren_q    <= 1'b0;
    end else begin
      load_enable_q <= 1'b0;
      tx_byte_q     <= 8'h00;
      tx_error_q    <= 1'b0;
      skip_q        <= 1'b0;
      pid_ren_q     <= 1'b0;
      nd_ren_q      <= 1'b0;
      data_ren_q    <= 1'b0;
      dcrc_ren_q    <= 1'b0;
      slot_cnt_q    <= slot_cnt_q + 8'd1;

      case (state_q)
        S_IDLE: begin
          slot_cnt_q   <= 8'd0;
          byte_cnt_q   <= 7'd0;
          busy_q       <= 1'b0;
          eop_enable_q <= 1'b0;
          // The pid_ren_q guard stops the same head from being judged again while its pop lands.
          if (bus.tx_enable && !bus.pid_empty && !pid_ren_q) begin
            if (!pid_ok) begin
              pid_ren_q  <= 1'b1;
              tx_error_q <= 1'b1;
            end else begin
              state_q       <= S_SYNC;
              busy_q        <= 1'b1;
              load_enable_q <= 1'b1;
              tx_byte_q     <= SYNC_BYTE;
            end
          end
        end

        S_SYNC: begin
          if (slot_end) begin
            state_q       <= S_PID;
            slot_cnt_q    <= 8'd0;
            load_enable_q <= 1'b1;
            tx_byte_q     <= bus.pid_rdata;
            pid_ren_q     <= 1'b1;
            cls_q         <= classify(bus.pid_rdata);
          end
        end

        S_PID: begin
          if (slot_end) begin
            slot_cnt_q <= 8'd0;
            second_q   <= 1'b0;
            case (cls_q)
              C_TOKEN: begin
                state_q <= S_TOKEN;
                if (bus.nd_empty) begin
                  skip_q     <= 1'b1;
                  tx_error_q <= 1'b1;
                end else begin
                  load_enable_q <= 1'b1;
                  tx_byte_q     <= bus.nd_rdata;
                  nd_ren_q      <= 1'b1;
                end
              end
              C_DATA: begin
                state_q <= S_DATA;
                if (bus.data_empty || byte_cnt_q == MAX_BYTES) begin
                  skip_q <= 1'b1;
                end else begin
                  load_enable_q <= 1'b1;
                  tx_byte_q     <= bus.data_rdata;
                  data_ren_q    <= 1'b1;
                  byte_cnt_q    <= byte_cnt_q + 7'd1;
                end
              end
              default: begin
                state_q      <= S_EOP;
                eop_enable_q <= 1'b1;
              end
            endcase
          end
        end

        S_TOKEN: begin
          if (skip_q || (slot_end && second_q)) begin
            state_q      <= S_EOP;
            slot_cnt_q   <= 8'd0;
            eop_enable_q <= 1'b1;
          end else if (slot_end) begin
            second_q   <= 1'b1;
            slot_cnt_q <= 8'd0;
            if (bus.nd_empty) begin
              skip_q     <= 1'b1;
              tx_error_q <= 1'b1;
            end else begin
              load_enable_q <= 1'b1;
              tx_byte_q     <= bus.nd_rdata;
              nd_ren_q      <= 1'b1;
            end
          end
        end

        S_DATA: begin
          if (skip_q) begin
            state_q    <= S_CRC;
            slot_cnt_q <= 8'd0;
            second_q   <= 1'b0;
            if (bus.dcrc_empty) begin
              skip_q     <= 1'b1;
              tx_error_q <= 1'b1;
            end else begin
              load_enable_q <= 1'b1;
              tx_byte_q     <= bus.dcrc_rdata;
              dcrc_ren_q    <= 1'b1;
            end
          end else if (slot_end) begin
            slot_cnt_q <= 8'd0;
            if (bus.data_empty || byte_cnt_q == MAX_BYTES) begin
              skip_q <= 1'b1;
            end else begin
              load_enable_q <= 1'b1;
              tx_byte_q     <= bus.data_rdata;
              data_ren_q    <= 1'b1;
              byte_cnt_q    <= byte_cnt_q + 7'd1;
            end
          end
        end

        S_CRC: begin
          if (skip_q || (slot_end && second_q)) begin
            state_q      <= S_EOP;
            slot_cnt_q   <= 8'd0;
            eop_enable_q <= 1'b1;
          end else if (slot_end) begin
            second_q   <= 1'b1;
            slot_cnt_q <= 8'd0;
            if (bus.dcrc_empty) begin
              skip_q     <= 1'b1;
              tx_error_q <= 1'b1;
            end else begin
              load_enable_q <= 1'b1;
              tx_byte_q     <= bus.dcrc_rdata;
              dcrc_ren_q    <= 1'b1;
            end
          end
        end

        S_EOP: begin
          if (slot_cnt_q == EOP_LAST) begin
            state_q      <= S_IDLE;
            slot_cnt_q   <= 8'd0;
            eop_enable_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        end

        default: begin
          state_q      <= S_IDLE;
          slot_cnt_q   <= 8'd0;
          eop_enable_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.load_enable = load_enable_q;
  assign bus.tx_byte     = tx_byte_q;
  assign bus.eop_enable  = eop_enable_q;
  assign bus.busy        = busy_q;
  assign bus.tx_error    = tx_error_q;
  assign bus.pid_ren     = pid_ren_q;
  assign bus.nd_ren      = nd_ren_q;
  assign bus.data_ren    = data_ren_q;
  assign bus.dcrc_ren    = dcrc_ren_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Bench for usb_tx_scheduler: FIFO models, a load scoreboard with per-byte timing,
// a table of packet scenarios and a mid-packet reset sequence.
module tb_usb_tx_scheduler;
  localparam int BC = 8;
  localparam int EC = 24;
  localparam int MP = 64;

  typedef struct {
    logic [7:0] pid;
    int n_nd, n_data, n_dcrc;
    int exp_loads, exp_err, exp_eop, exp_left;
  } vec_t;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [2:0] state_dbg;

  usb_tx_scheduler_if bus();

  usb_tx_scheduler #(.BYTE_CLKS(BC), .EOP_CLKS(EC), .MAX_PAYLOAD(MP)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .bus     (bus),
    .state_o (state_dbg)
  );

  always #5 clk = ~clk;

  logic [7:0] pid_fifo[$];
  logic [7:0] nd_fifo[$];
  logic [7:0] data_fifo[$];
  logic [7:0] dcrc_fifo[$];
  logic [7:0] exp_q[$];
  int         gap_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_load_cyc = 0;
  int eop_gap_seen = 0;
  int n_loads = 0, n_err = 0, n_eop = 0, n_busy = 0;
  int n_pid_ren = 0, n_nd_ren = 0, n_data_ren = 0, n_dcrc_ren = 0;
  int n_multi = 0, n_bad_byte = 0, n_busy_bad = 0;
  logic tx_en_prev = 1'b0;
  logic eop_prev = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor, scoreboard and FIFO models all run at the negative edge.
  always @(negedge clk) begin : mon_blk
    logic [7:0] e;
    int g;
    int rens;
    cyc++;
    if (bus.tx_enable && !tx_en_prev) last_load_cyc = cyc;
    tx_en_prev = bus.tx_enable;
    if (bus.load_enable) begin
      check("load_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = gap_q.pop_front();
        check("tx_byte", int'(bus.tx_byte), int'(e));
        check("load_gap", cyc - last_load_cyc, g);
      end
      last_load_cyc = cyc;
      n_loads++;
    end else if (bus.tx_byte != 8'h00) begin
      n_bad_byte++;
    end
    if (bus.eop_enable && !eop_prev) eop_gap_seen = cyc - last_load_cyc;
    if (!bus.eop_enable && eop_prev && bus.busy) n_busy_bad++;
    eop_prev = bus.eop_enable;
    if (bus.eop_enable) n_eop++;
    if (bus.tx_error) n_err++;
    if (bus.busy) n_busy++;
    rens = int'(bus.pid_ren) + int'(bus.nd_ren) + int'(bus.data_ren) + int'(bus.dcrc_ren);
    if (rens > 1) n_multi++;
    if (bus.pid_ren) n_pid_ren++;
    if (bus.nd_ren) n_nd_ren++;
    if (bus.data_ren) n_data_ren++;
    if (bus.dcrc_ren) n_dcrc_ren++;
    if (bus.pid_ren && pid_fifo.size() > 0) void'(pid_fifo.pop_front());
    if (bus.nd_ren && nd_fifo.size() > 0) void'(nd_fifo.pop_front());
    if (bus.data_ren && data_fifo.size() > 0) void'(data_fifo.pop_front());
    if (bus.dcrc_ren && dcrc_fifo.size() > 0) void'(dcrc_fifo.pop_front());
    bus.pid_empty  = (pid_fifo.size() == 0);
    bus.pid_rdata  = (pid_fifo.size() > 0) ? pid_fifo[0] : 8'h00;
    bus.nd_empty   = (nd_fifo.size() == 0);
    bus.nd_rdata   = (nd_fifo.size() > 0) ? nd_fifo[0] : 8'h00;
    bus.data_empty = (data_fifo.size() == 0);
    bus.data_rdata = (data_fifo.size() > 0) ? data_fifo[0] : 8'h00;
    bus.dcrc_empty = (dcrc_fifo.size() == 0);
    bus.dcrc_rdata = (dcrc_fifo.size() > 0) ? dcrc_fifo[0] : 8'h00;
  end

  // Fill the FIFOs for one scenario and push the expected load stream with per-load gaps.
  task automatic load_row(input vec_t r, output int eop_gap, output int e_nd,
                          output int e_dp, output int e_cp);
    logic [3:0] hi;
    logic [3:0] lo;
    eop_gap = 0; e_nd = 0; e_dp = 0; e_cp = 0;
    pid_fifo.push_back(r.pid);
    for (int i = 0; i < r.n_nd; i++) nd_fifo.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < r.n_data; i++) data_fifo.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < r.n_dcrc; i++) dcrc_fifo.push_back(8'($urandom_range(0, 255)));
    hi = r.pid[7:4];
    lo = r.pid[3:0];
    if (hi == ~lo) begin
      exp_q.push_back(8'h80); gap_q.push_back(1);
      exp_q.push_back(r.pid); gap_q.push_back(BC);
      case (r.pid)
        8'hE1, 8'h69, 8'hA5, 8'h2D: begin
          e_nd = (r.n_nd < 2) ? r.n_nd : 2;
          for (int k = 0; k < e_nd; k++) begin
            exp_q.push_back(nd_fifo[k]); gap_q.push_back(BC);
          end
          eop_gap = (e_nd == 2) ? BC : BC + 1;
        end
        8'hC3, 8'h4B: begin
          e_dp = (r.n_data < MP) ? r.n_data : MP;
          for (int k = 0; k < e_dp; k++) begin
            exp_q.push_back(data_fifo[k]); gap_q.push_back(BC);
          end
          e_cp = (r.n_dcrc < 2) ? r.n_dcrc : 2;
          for (int k = 0; k < e_cp; k++) begin
            exp_q.push_back(dcrc_fifo[k]); gap_q.push_back((k == 0) ? BC + 1 : BC);
          end
          eop_gap = (e_cp == 2) ? BC : ((e_cp == 1) ? BC + 1 : BC + 2);
        end
        default: eop_gap = BC;
      endcase
    end
  endtask

  task automatic clear_fifos();
    pid_fifo.delete(); nd_fifo.delete(); data_fifo.delete(); dcrc_fifo.delete();
    exp_q.delete(); gap_q.delete();
  endtask

  task automatic run_row(input vec_t r);
    int eg, e_nd, e_dp, e_cp;
    int s_loads, s_err, s_eop, s_busy, s_pid, s_nd, s_dp, s_cp, s_multi, s_bad, s_bb;
    bit done;
    load_row(r, eg, e_nd, e_dp, e_cp);
    repeat (2) @(posedge clk);
    #1;
    s_loads = n_loads; s_err = n_err; s_eop = n_eop; s_busy = n_busy;
    s_pid = n_pid_ren; s_nd = n_nd_ren; s_dp = n_data_ren; s_cp = n_dcrc_ren;
    s_multi = n_multi; s_bad = n_bad_byte; s_bb = n_busy_bad;
    bus.tx_enable = 1'b1;
    done = 1'b0;
    for (int t = 0; t < 5000 && !done; t++) begin
      @(posedge clk);
      #1;
      if (t >= 2 && pid_fifo.size() == 0 && !bus.busy && !bus.eop_enable) done = 1'b1;
    end
    check("row_done", int'(done), 1);
    bus.tx_enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("load_count", n_loads - s_loads, r.exp_loads);
    check("tx_error_pulses", n_err - s_err, r.exp_err);
    check("eop_cycles", n_eop - s_eop, r.exp_eop);
    check("data_left", data_fifo.size(), r.exp_left);
    check("pid_pops", n_pid_ren - s_pid, 1);
    check("nd_pops", n_nd_ren - s_nd, e_nd);
    check("data_pops", n_data_ren - s_dp, e_dp);
    check("dcrc_pops", n_dcrc_ren - s_cp, e_cp);
    check("ren_overlap", n_multi - s_multi, 0);
    check("idle_tx_byte", n_bad_byte - s_bad, 0);
    check("busy_after_eop", n_busy_bad - s_bb, 0);
    check("scoreboard_drained", exp_q.size(), 0);
    if (r.exp_eop > 0) check("eop_latency", eop_gap_seen, eg);
    if (r.exp_loads == 0) check("busy_on_drop", n_busy - s_busy, 0);
    clear_fifos();
  endtask

  initial begin : test_blk
    vec_t vecs[12];
    int s_loads, s_ren;
    bit done;
    vecs[0]  = '{8'hD2, 0, 0,  0,  2, 0, 24, 0};
    vecs[1]  = '{8'h69, 2, 0,  0,  4, 0, 24, 0};
    vecs[2]  = '{8'hC3, 0, 3,  2,  7, 0, 24, 0};
    vecs[3]  = '{8'h4B, 0, 70, 2, 68, 0, 24, 6};
    vecs[4]  = '{8'h12, 0, 0,  0,  0, 1,  0, 0};
    vecs[5]  = '{8'hE1, 1, 0,  0,  3, 1, 24, 0};
    vecs[6]  = '{8'hC3, 0, 0,  2,  4, 0, 24, 0};
    vecs[7]  = '{8'h4B, 0, 2,  0,  4, 1, 24, 0};
    vecs[8]  = '{8'hA5, 2, 0,  0,  4, 0, 24, 0};
    vecs[9]  = '{8'hF0, 0, 0,  0,  2, 0, 24, 0};
    vecs[10] = '{8'h2D, 2, 0,  0,  4, 0, 24, 0};
    vecs[11] = '{8'h1E, 0, 0,  0,  2, 0, 24, 0};

    n_rst = 1'b0;
    bus.tx_enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_load_enable", int'(bus.load_enable), 0);
    check("rst_tx_byte", int'(bus.tx_byte), 0);
    check("rst_eop", int'(bus.eop_enable), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_tx_error", int'(bus.tx_error), 0);
    check("rst_state", int'(state_dbg), 0);
    n_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) run_row(vecs[i]);

    // Reset during the second data slot abandons the packet.
    pid_fifo.push_back(8'hC3);
    for (int i = 0; i < 5; i++) data_fifo.push_back(8'($urandom_range(0, 255)));
    dcrc_fifo.push_back(8'hAB);
    dcrc_fifo.push_back(8'hCD);
    exp_q.push_back(8'h80);        gap_q.push_back(1);
    exp_q.push_back(8'hC3);        gap_q.push_back(BC);
    exp_q.push_back(data_fifo[0]); gap_q.push_back(BC);
    exp_q.push_back(data_fifo[1]); gap_q.push_back(BC);
    repeat (2) @(posedge clk);
    #1;
    s_loads = n_loads;
    bus.tx_enable = 1'b1;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(posedge clk);
      #1;
      if (n_loads - s_loads >= 4) done = 1'b1;
    end
    check("rst_reach_data_slot2", int'(done), 1);
    repeat (3) @(posedge clk);
    #1;
    bus.tx_enable = 1'b0;
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_state", int'(state_dbg), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_eop", int'(bus.eop_enable), 0);
    check("midrst_load", int'(bus.load_enable), 0);
    check("midrst_tx_byte", int'(bus.tx_byte), 0);
    check("midrst_tx_error", int'(bus.tx_error), 0);
    check("midrst_ren", int'(bus.pid_ren) + int'(bus.nd_ren) + int'(bus.data_ren) + int'(bus.dcrc_ren), 0);
    n_rst = 1'b1;
    exp_q.delete();
    gap_q.delete();
    s_loads = n_loads;
    s_ren = n_pid_ren + n_nd_ren + n_data_ren + n_dcrc_ren;
    repeat (30) @(posedge clk);
    #1;
    check("postrst_loads", n_loads - s_loads, 0);
    check("postrst_pops", n_pid_ren + n_nd_ren + n_data_ren + n_dcrc_ren - s_ren, 0);
    check("postrst_data_left", data_fifo.size(), 3);
    check("postrst_eop", int'(bus.eop_enable), 0);
    clear_fifos();
    run_row(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
